// File: rtl/conv1_frame_sequencer.sv
// conv1_frame_sequencer
//
// Frame-level controller for the first binary convolution layer. It holds one
// IMG_W x IMG_H binary image in a local bit buffer. On start it releases the
// conv layer from reset, streams the pixels one per clock (row-major), and
// then counts the layer's valid pulses until the expected count is reached or
// the drain timeout expires.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   buffer write strobe (honoured only when idle and start=0)
//   wr_addr     in   [9:0] pixel address, row*IMG_W+col
//   wr_data     in   pixel value
//   start       in   begin a frame; sampled only while idle
//   conv_valid  in   valid_out_conv1 from the conv layer
//   conv_rst_n  out  drives the conv layer rst_n (held low while idle)
//   pixel_out   out  drives the conv layer pixel_in
//   busy        out  high from start acceptance until frame completion
//   done        out  one-cycle completion pulse
//   error       out  last frame ended with a wrong output count (sticky)
//   out_count   out  [9:0] valid pulses counted in the current/last frame
//
// Interface semantics: there is no backpressure anywhere. start is a request
// that is consumed only in IDLE; conv_valid is a one-way strobe counted on
// every edge while a frame is active; pixel_out is presented for exactly one
// cycle per pixel and the conv layer must take it on the following edge.
//
// All outputs are registers. The buffer has no reset so a mid-frame reset
// leaves the image intact for the next frame.

module conv1_frame_sequencer #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int OUT_COUNT = 676,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic       wr_data,
  input  logic       start,
  input  logic       conv_valid,
  output logic       conv_rst_n,
  output logic       pixel_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [9:0] out_count
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int DW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    idx_q, idx_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          pix_d, crst_d, busy_d, done_d, err_d;
  logic [9:0]    cnt_d, cnt_upd;
  logic          wr_accept;
  logic          frame_end;

  // ---------------------------------------------------------------------------
  // Image buffer: one bit per pixel, deliberately not reset.
  // Writes are refused while a frame runs and in the start-acceptance cycle,
  // so the image being streamed can never change underneath the stream.
  // ---------------------------------------------------------------------------
  logic pix_buf [NPIX];

  assign wr_accept = wr_en && (wr_addr < 10'(NPIX)) &&
                     (state_q == S_IDLE) && !start;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      pix_buf[wr_addr] <= wr_data;
    end
  end

  // Saturating increment of the pulse counter (stays at 1023).
  assign cnt_upd = (conv_valid && (out_count != 10'h3FF)) ?
                   out_count + 10'd1 : out_count;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    pix_d     = pixel_out;
    crst_d    = conv_rst_n;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = error;
    cnt_d     = out_count;
    frame_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Pulses arriving while idle are ignored; count/error hold.
        if (start) begin
          state_d = S_STREAM;
          crst_d  = 1'b1;
          pix_d   = pix_buf[0];
          idx_d   = 10'd1;
          cnt_d   = 10'd0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_STREAM: begin
        cnt_d = cnt_upd;
        // idx_q == NPIX means the last pixel went out on the previous edge.
        if (idx_q == 10'(NPIX)) begin
          state_d = S_DRAIN;
          pix_d   = 1'b0;
          drain_d = '0;
        end else begin
          pix_d = pix_buf[idx_q];
          idx_d = idx_q + 10'd1;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_upd;
        // The exit test looks at the count registered before this edge;
        // the error flag includes any pulse counted at this very edge.
        frame_end = (out_count >= 10'(OUT_COUNT)) ||
                    (drain_q == DW'(TIMEOUT - 1));
        if (frame_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          crst_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = (cnt_upd != 10'(OUT_COUNT));
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        crst_d  = 1'b0;
        pix_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 10'd0;
      drain_q    <= '0;
      pixel_out  <= 1'b0;
      conv_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      out_count  <= 10'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      pixel_out  <= pix_d;
      conv_rst_n <= crst_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= err_d;
      out_count  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_conv1_frame_sequencer.sv
// tb_conv1_frame_sequencer
//
// Bench for conv1_frame_sequencer. Drivers issue buffer writes and frames;
// for each frame the expected pixel stream and the expected completion
// (edge offset from the start edge, final count, error flag) are pushed into
// queues. A negedge monitor pops and compares whenever the DUT presents a
// pixel or a done pulse. The reference model works directly from the frame
// rules: an array image plus a per-edge pulse schedule.

module tb_conv1_frame_sequencer;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int OUT_COUNT = 676;
  localparam int TIMEOUT   = 64;
  localparam int LAST_EDGE = NPIX + TIMEOUT;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic       wr_data;
  logic       start;
  logic       conv_valid;
  logic       conv_rst_n;
  logic       pixel_out;
  logic       busy;
  logic       done;
  logic       error;
  logic [9:0] out_count;

  always #5 clk = ~clk;

  conv1_frame_sequencer #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .OUT_COUNT(OUT_COUNT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .conv_valid(conv_valid),
    .conv_rst_n(conv_rst_n),
    .pixel_out (pixel_out),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .out_count (out_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        model_buf [NPIX];
  bit          sched [0:1023];
  logic [0:0]  exp_pix_q[$];
  logic [21:0] exp_done_q[$];   // {edge[10:0], count[9:0], error}

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void clear_sched();
    for (int e = 0; e < 1024; e++) sched[e] = 1'b0;
  endfunction

  // Scatter n pulses over distinct edges in [lo, hi].
  function automatic void place_pulses(input int n, input int lo, input int hi);
    int placed = 0;
    while (placed < n) begin
      int p = $urandom_range(hi, lo);
      if (!sched[p]) begin
        sched[p] = 1'b1;
        placed++;
      end
    end
  endfunction

  // Edge numbering: E0 samples start, pixel k is counted at edges 1..784.
  // Draining edges 785..848: the frame ends at the first one where the count
  // so far already reaches OUT_COUNT, or at the last one; the pulse at the
  // ending edge still counts.
  function automatic void model_frame(output int d_edge, output int cnt);
    int c = 0;
    d_edge = LAST_EDGE;
    for (int e = 1; e <= NPIX; e++) c += int'(sched[e]);
    for (int e = NPIX + 1; e <= LAST_EDGE; e++) begin
      bit ends = (c >= OUT_COUNT) || (e == LAST_EDGE);
      c += int'(sched[e]);
      if (ends) begin
        d_edge = e;
        break;
      end
    end
    cnt = (c > 1023) ? 1023 : c;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares at negedge, away from the active edge
  // ---------------------------------------------------------------------------
  int   off = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) off = 0;
      else off++;

      if (busy) begin
        check("busy_conv_rst_n", conv_rst_n, 1);
        if (off < NPIX) begin
          if (exp_pix_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pix_underflow: pixel %0d presented with none expected at %0t",
                     off, $time);
          end else begin
            logic [0:0] ep;
            ep = exp_pix_q.pop_front();
            check("pixel", pixel_out, ep);
          end
        end else begin
          check("drain_pixel", pixel_out, 0);
        end
      end else begin
        check("idle_pixel", pixel_out, 0);
        check("idle_conv_rst_n", conv_rst_n, 0);
      end

      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_underflow: done seen with none expected at %0t", $time);
        end else begin
          logic [21:0] ed;
          ed = exp_done_q.pop_front();
          check("done_edge", off, ed[21:11]);
          check("done_out_count", out_count, ed[10:1]);
          check("done_error", error, ed[0]);
          check("done_busy", busy, 0);
          check("done_width", prev_done, 0);
        end
      end

      prev_busy = busy;
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge+1, DUT idle unless stated)
  // ---------------------------------------------------------------------------
  task automatic write_pix(input int addr, input logic d);
    wr_en   = 1'b1;
    wr_addr = addr[9:0];
    wr_data = d;
    if (addr < NPIX) model_buf[addr] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_checker();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        write_pix(r * IMG_W + c, logic'((r + c) % 2));
  endtask

  task automatic load_random();
    for (int a = 0; a < NPIX; a++) write_pix(a, logic'($urandom_range(1, 0)));
    repeat (3) write_pix($urandom_range(1023, NPIX), 1'b1);
  endtask

  // Run one complete frame against the current schedule. With noise set,
  // writes hammer the buffer during the frame (and in the start cycle) and
  // start is re-asserted during STREAM and at the completion edge.
  task automatic run_frame(input bit noise);
    int d_edge;
    int cnt;
    int n;
    model_frame(d_edge, cnt);
    for (int k = 0; k < NPIX; k++) exp_pix_q.push_back(model_buf[k]);
    exp_done_q.push_back({11'(d_edge), 10'(cnt), 1'(cnt != OUT_COUNT)});

    start = 1'b1;
    if (noise) begin
      wr_en   = 1'b1;
      wr_addr = 10'($urandom_range(NPIX - 1, 0));
      wr_data = ~model_buf[wr_addr];
    end
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    wr_en = 1'b0;
    for (int e = 1; e <= d_edge; e++) begin
      conv_valid = sched[e];
      if (noise) begin
        wr_en   = (e < NPIX);
        wr_addr = 10'($urandom_range(NPIX - 1, 0));
        wr_data = 1'b1;
        start   = ((e < NPIX) && ($urandom_range(7, 0) == 0)) || (e == d_edge);
      end
      @(posedge clk); #1;                     // E_e
    end
    conv_valid = 1'b0;
    start      = 1'b0;
    wr_en      = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_finished", busy, 0);
  endtask

  // Start a frame and pull rst_n low mid-cycle after edge stop_edge.
  task automatic reset_frame(input int stop_edge);
    for (int k = 0; k < NPIX; k++) exp_pix_q.push_back(model_buf[k]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= stop_edge; e++) begin
      conv_valid = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    conv_valid = 1'b0;
    #1;
    check("rst_async_conv_rst_n", conv_rst_n, 0);
    check("rst_async_pixel_out", pixel_out, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_error", error, 0);
    check("rst_async_out_count", out_count, 0);
    exp_pix_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 10'd0;
    wr_data    = 1'b0;
    start      = 1'b0;
    conv_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_conv_rst_n", conv_rst_n, 0);
    check("reset_pixel_out", pixel_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_out_count", out_count, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    load_checker();

    // Exactly OUT_COUNT pulses, all before the drain: earliest completion.
    clear_sched();
    place_pulses(OUT_COUNT, 10, NPIX);
    run_frame(1'b0);

    // Too few pulses: timeout, error set. Back-to-back with the previous done.
    clear_sched();
    place_pulses(600, 10, NPIX);
    run_frame(1'b0);

    // Out-of-range write in IDLE, then writes/starts while busy: all dropped.
    write_pix(900, 1'b1);
    clear_sched();
    place_pulses(OUT_COUNT, 100, 820);
    run_frame(1'b1);

    // Reset mid-frame, then the intact image streams again from pixel 0.
    reset_frame(400);
    clear_sched();
    place_pulses(OUT_COUNT, 1, NPIX);
    run_frame(1'b0);

    // One excess pulse exactly at the completion edge.
    clear_sched();
    place_pulses(OUT_COUNT, 1, NPIX);
    sched[NPIX + 1] = 1'b1;
    run_frame(1'b0);

    // Random images and pulse patterns.
    repeat (4) begin
      int n;
      int span;
      int lo;
      load_random();
      clear_sched();
      n    = $urandom_range(720, 560);
      span = n + $urandom_range(100, 0);
      if (span > LAST_EDGE) span = LAST_EDGE;
      lo   = $urandom_range(LAST_EDGE - span + 1, 1);
      place_pulses(n, lo, lo + span - 1);
      run_frame(1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("pix_q_left", exp_pix_q.size(), 0);
    check("done_q_left", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv1_frame_sequencer.md
# conv1_frame_sequencer

Frame-level controller for the first binary convolution layer. Holds one 28x28 binary image in a local bit buffer loaded over a simple write port. On `start` it releases the conv layer from reset, streams the 784 pixels one per clock, then counts the layer's valid outputs until the expected count arrives or a timeout expires. It sits between the image source and `conv_layer_1`, and drives that layer's `pixel_in` and `rst_n`.

## Interface
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `OUT_COUNT`, 676, expected number of `valid_out_conv1` pulses per frame (26x26)
- `TIMEOUT`, 64, maximum cycles spent in DRAIN before aborting
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  10  pixel address, row*IMG_W+col
- `wr_data`  in  1  pixel value
- `start`  in  1  begin a frame; sampled only in IDLE
- `conv_valid`  in  1  connected to `valid_out_conv1`
- `conv_rst_n`  out  1  drives conv layer `rst_n`
- `pixel_out`  out  1  drives conv layer `pixel_in`
- `busy`  out  1  high from start acceptance until frame completion
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  frame ended with a wrong output count; sticky until next accepted start
- `out_count`  out  10  valid pulses counted in the current or last frame

## Operation
- Buffer: 784 x 1 bit, not reset. A write occurs at the edge when `wr_en`=1, `wr_addr`<784, and state is IDLE with `start`=0. All other writes are dropped: out-of-range, while busy, or in the start-acceptance cycle.
- FSM states:
  - IDLE: `conv_rst_n`=0, `pixel_out`=0, `busy`=0.
  - `start`=1 → STREAM. At the same edge: `conv_rst_n`←1, `pixel_out`←buf[0], pixel index←1, `out_count`←0, `error`←0.
  - STREAM: each edge loads `pixel_out`←buf[idx] and increments idx. At the edge after buf[783] is loaded → DRAIN, with `pixel_out`←0 and drain counter←0.
  - DRAIN: if `out_count` >= `OUT_COUNT`, → IDLE. Otherwise, if the drain counter = `TIMEOUT`-1, → IDLE. Otherwise increment the drain counter.
  - At the transition to IDLE: `done`←1 for one cycle, `conv_rst_n`←0, and `error`←(`out_count` != `OUT_COUNT`), evaluated including any pulse counted at that edge.
- Counting: `conv_valid`=1 at an edge in STREAM or DRAIN increments `out_count`. The count saturates at 1023. Pulses in IDLE are ignored.
- `start` while busy is ignored; no queuing.
- `out_count` and `error` hold their values in IDLE until the next accepted start.

## Timing
- Reset values: `conv_rst_n`=0, `pixel_out`=0, `busy`=0, `done`=0, `error`=0, `out_count`=0, state IDLE.
- `rst_n` low mid-frame aborts immediately to reset values. No `done` pulse is produced. Buffer contents are retained.
- All outputs are registered.
- Let E0 be the edge sampling `start`:
  - Pixel k is on `pixel_out` between E_k and E_k+1, for k=0..783. The conv layer therefore samples pixel k at E_k+1.
  - `busy` goes high at E0.
  - STREAM→DRAIN occurs at E784.
  - The earliest `done` is at E785, and only if `OUT_COUNT` pulses have already been counted.
  - The latest `done` is at E784+`TIMEOUT`.
- `busy` falls at the same edge `done` rises.
- The first accepted `start` can be 1 cycle after `done`.
- Excess pulses arriving in the cycle of the final count are still counted, and they set `error`.

## Test plan
- Load a checkerboard, buf[r*28+c]=(r+c)%2. Start, with a model returning exactly 676 `conv_valid` pulses → `pixel_out` sequence matches the buffer from E0 to E783, `done` fires, `error`=0, `out_count`=676.
- Same frame, model returns only 600 pulses → `done` at E784+64, `error`=1, `out_count`=600.
- Write all-ones with `wr_en` during STREAM, plus a write to `wr_addr`=900 in IDLE → buffer unchanged, the next frame streams the original image.
- Assert `start` during STREAM and in the `done` cycle → ignored; `busy` and `done` each pulse only once per frame.
- Drop `rst_n` at E400 → all outputs take reset values asynchronously. A new start streams the intact buffer from pixel 0.
- Send 677 pulses, with the extra one arriving at the completion edge → `error`=1, `out_count`=677.
